hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage MIPS core; sits beside the forwarding unit and drives PC/IF-ID write enables and IF-ID/ID-EX flushes.
- Detects load-use hazards that forwarding cannot cover and applies control-flow flushes.
- Runs a multi-cycle MULT/DIV busy sequencer that owns HI/LO write timing and stalls ID-stage consumers of HI/LO.

Parameters:
- MUL_LAT, 4, cycles a MULT/MULTU occupies the unit after issue (≥1)
- DIV_LAT, 32, cycles a DIV/DIVU occupies the unit after issue (≥1)
- CNT_W, 6, width of the latency down-counter; must hold max(MUL_LAT,DIV_LAT)-1

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ifid_rs  in  5  rs field of the instruction in ID
- ifid_rt  in  5  rt field of the instruction in ID
- ifid_uses_rt  in  1  ID instruction reads rt as a source
- ifid_reads_hilo  in  1  ID instruction is MFHI/MFLO
- ifid_is_md  in  1  ID instruction is MULT/MULTU/DIV/DIVU
- idex_memread  in  1  EX instruction is a load
- idex_rt  in  5  destination register of the EX load
- md_start  in  1  MULT/DIV instruction is in EX this cycle
- md_is_div  in  1  qualifies md_start: 1=divide, 0=multiply
- branch_taken  in  1  branch resolved taken in EX
- jump  in  1  J/JAL/JR decoded in ID
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_flush  out  1  insert bubble into ID/EX
- md_busy  out  1  multiply/divide unit occupied
- md_done  out  1  one-cycle pulse: HI/LO result valid this cycle
- hilo_we  out  1  HI/LO write enable, equal to md_done
- stall_cycles  out  32  count of cycles with stall asserted

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, stall_cycles=0; md_busy=0, md_done=0, hilo_we=0. Other outputs are combinational from inputs and state.
- load_use = idex_memread && idex_rt!=0 && (idex_rt==ifid_rs || (ifid_uses_rt && idex_rt==ifid_rt)).
- hilo_haz = ifid_reads_hilo && (md_busy || md_start).
- md_struct = ifid_is_md && (md_busy || md_start).
- stall = (load_use || hilo_haz || md_struct) && !branch_taken.
- Output priority, highest first:
  1. branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1. Stall is suppressed; jump is ignored.
  2. stall: pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1.
  3. jump: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=0.
  4. Otherwise: pc_write=1, ifid_write=1, both flushes 0.
- Load-use stall lasts exactly 1 cycle. The next cycle the load is in MEM and the forwarding unit covers the dependency.
- MD sequencer, states IDLE, BUSY:
  - IDLE & md_start: cnt <= (md_is_div ? DIV_LAT : MUL_LAT) - 1; go BUSY.
  - BUSY & cnt!=0: cnt <= cnt-1.
  - BUSY & cnt==0: go IDLE.
  - md_busy = (state==BUSY).
  - md_done = hilo_we = (state==BUSY && cnt==0), combinational from registers, exactly one cycle.
  - Net effect: md_start at cycle T gives md_busy high during T+1..T+LAT and md_done at T+LAT.
  - md_start while BUSY is ignored: no reload, count is not disturbed. Upstream stall prevents this case.
  - branch_taken does not abort an in-flight MD operation. The MD instruction has already passed EX, so it is on the correct path.
- HI/LO hazard: MFHI/MFLO in ID stalls from the md_start cycle through the md_done cycle inclusive. It proceeds the cycle after md_done, when HI/LO already holds the result.
- stall_cycles increments by 1 on each clk where stall=1 and wraps at 2^32.
- Reset mid-operation: BUSY aborts to IDLE immediately; md_done is not produced.

Test Plan:
- idex_memread=1, idex_rt=8, ifid_rs=8 → 1 cycle of pc_write=0, ifid_write=0, idex_flush=1; the next cycle with idex_memread=0 gives all writes 1. Repeat with idex_rt=0 → no stall.
- Same load-use condition plus branch_taken=1 → pc_write=1, ifid_flush=1, idex_flush=1, stall_cycles unchanged.
- md_start=1, md_is_div=0 at cycle 10 → md_busy high cycles 11–14, md_done/hilo_we high only in cycle 14, IDLE at cycle 15.
- DIV issued, MFHI enters ID in the same cycle → stall held 33 cycles (start cycle through md_done cycle); pc_write=1 on the cycle after md_done; stall_cycles=33.
- Second MULT in ID while DIV is busy → md_struct stall; after release, a new md_start reloads cnt=3 correctly.
- rst_n pulsed low mid-DIV at cnt=10 → md_busy=0 immediately, no md_done pulse, stall_cycles=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and sequencing controller for the 5-stage MIPS core.
//
// Detects load-use hazards that forwarding cannot cover. Applies control-flow
// flushes for taken branches and jumps. Runs the multi-cycle MULT/DIV busy
// sequencer, which owns HI/LO write timing and stalls HI/LO consumers in ID.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   ifid_rs/rt        source fields of the ID instruction
//   ifid_uses_rt      ID instruction reads rt
//   ifid_reads_hilo   ID instruction is MFHI/MFLO
//   ifid_is_md        ID instruction is MULT/MULTU/DIV/DIVU
//   idex_memread/rt   EX instruction is a load, and its destination register
//   md_start          MULT/DIV instruction is in EX this cycle
//   md_is_div         selects the divide latency when md_start is high
//   branch_taken      branch resolved taken in EX
//   jump              J/JAL/JR decoded in ID
//   pc_write          PC register enable
//   ifid_write        IF/ID register enable
//   ifid_flush        clear IF/ID to NOP
//   idex_flush        insert a bubble into ID/EX
//   md_busy           MD unit occupied
//   md_done           one-cycle pulse; HI/LO result is valid this cycle
//   hilo_we           HI/LO write enable, identical to md_done
//   stall_cycles      free-running count of stalled cycles (wraps at 2^32)
module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        ifid_uses_rt,
  input  logic        ifid_reads_hilo,
  input  logic        ifid_is_md,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        branch_taken,
  input  logic        jump,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic        hilo_we,
  output logic [31:0] stall_cycles
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // The counter is loaded with LAT-1. The done cycle is then the BUSY cycle
  // in which the count reaches zero, which is exactly LAT cycles after issue.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stall_cycles_q, stall_cycles_d;

  logic load_use;
  logic hilo_haz;
  logic md_struct;
  logic stall;

  // Hazard detection. A taken branch squashes the ID instruction, so it
  // overrides every stall reason.
  always_comb begin
    load_use  = idex_memread && (idex_rt != 5'd0) &&
                ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    hilo_haz  = ifid_reads_hilo && (md_busy || md_start);
    md_struct = ifid_is_md && (md_busy || md_start);
    stall     = (load_use || hilo_haz || md_struct) && !branch_taken;
  end

  // Pipeline enables and flushes. Priority order: branch, stall, jump.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (jump) begin
      ifid_flush = 1'b1;
    end else begin
      pc_write   = 1'b1;
    end
  end

  // MD sequencer next state. md_start while BUSY is ignored on purpose.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (md_start) begin
          state_d = BUSY;
          cnt_d   = md_is_div ? DIV_LOAD : MUL_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Stall statistics counter; natural 32-bit wrap.
  always_comb begin
    if (stall) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // State, counter and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Sequencer status, decoded directly from registers so it is glitch-free
  // and drops at once on reset.
  always_comb begin
    md_busy      = (state_q == BUSY);
    md_done      = (state_q == BUSY) && (cnt_q == '0);
    hilo_we      = md_done;
    stall_cycles = stall_cycles_q;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ifid_rs, ifid_rt, idex_rt;
  logic        ifid_uses_rt, ifid_reads_hilo, ifid_is_md, idex_memread;
  logic        md_start, md_is_div, branch_taken, jump;
  logic        pc_write, ifid_write, ifid_flush, idex_flush;
  logic        md_busy, md_done, hilo_we;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model. The MD unit is described by the cycle number of its
  // issue and its latency, not by a counter.
  int unsigned cyc = 0;
  bit          md_act = 1'b0;
  int unsigned md_t0 = 0;
  int unsigned md_lat = 0;
  logic [31:0] m_stalls = 32'd0;
  int          obs_busy = 0;
  int          obs_done = 0;

  hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .ifid_reads_hilo(ifid_reads_hilo), .ifid_is_md(ifid_is_md),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .md_start(md_start), .md_is_div(md_is_div),
    .branch_taken(branch_taken), .jump(jump),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .md_busy(md_busy), .md_done(md_done), .hilo_we(hilo_we),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit m_busy();
    return md_act && (cyc > md_t0) && (cyc <= md_t0 + md_lat);
  endfunction

  function automatic bit m_done();
    return md_act && (cyc == md_t0 + md_lat);
  endfunction

  task automatic idle_inputs();
    ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rt = 5'd0;
    ifid_uses_rt = 1'b0; ifid_reads_hilo = 1'b0; ifid_is_md = 1'b0;
    idex_memread = 1'b0; md_start = 1'b0; md_is_div = 1'b0;
    branch_taken = 1'b0; jump = 1'b0;
  endtask

  // One clock cycle: called at a negedge with inputs already applied.
  task automatic step();
    bit lu, hh, ms, st;
    bit e_pc, e_ifw, e_iff, e_idf;
    #2;
    lu = idex_memread && (idex_rt != 5'd0) &&
         ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    hh = ifid_reads_hilo && (m_busy() || md_start);
    ms = ifid_is_md && (m_busy() || md_start);
    st = (lu || hh || ms) && !branch_taken;
    if (branch_taken) begin
      e_pc = 1'b1; e_ifw = 1'b1; e_iff = 1'b1; e_idf = 1'b1;
    end else if (st) begin
      e_pc = 1'b0; e_ifw = 1'b0; e_iff = 1'b0; e_idf = 1'b1;
    end else if (jump) begin
      e_pc = 1'b1; e_ifw = 1'b1; e_iff = 1'b1; e_idf = 1'b0;
    end else begin
      e_pc = 1'b1; e_ifw = 1'b1; e_iff = 1'b0; e_idf = 1'b0;
    end
    check_val("pc_write",     {31'd0, pc_write},   {31'd0, e_pc});
    check_val("ifid_write",   {31'd0, ifid_write}, {31'd0, e_ifw});
    check_val("ifid_flush",   {31'd0, ifid_flush}, {31'd0, e_iff});
    check_val("idex_flush",   {31'd0, idex_flush}, {31'd0, e_idf});
    check_val("md_busy",      {31'd0, md_busy},    {31'd0, m_busy()});
    check_val("md_done",      {31'd0, md_done},    {31'd0, m_done()});
    check_val("hilo_we",      {31'd0, hilo_we},    {31'd0, m_done()});
    check_val("stall_cycles", stall_cycles,        m_stalls);
    if (md_busy) obs_busy++;
    if (md_done) obs_done++;
    @(posedge clk);
    if (m_done()) md_act = 1'b0;
    else if (!md_act && md_start) begin
      md_act = 1'b1;
      md_t0  = cyc;
      md_lat = md_is_div ? DIV_LAT : MUL_LAT;
    end
    if (st) m_stalls = m_stalls + 32'd1;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] base;
    idle_inputs();
    rst_n = 1'b0;
    #3;
    check_val("rst_md_busy", {31'd0, md_busy}, 32'd0);
    check_val("rst_md_done", {31'd0, md_done}, 32'd0);
    check_val("rst_hilo_we", {31'd0, hilo_we}, 32'd0);
    check_val("rst_stalls",  stall_cycles,     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Load-use stall lasts one cycle, then the load has moved on.
    idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
    step();
    idex_memread = 1'b0;
    step();
    // Zero register never creates a hazard.
    idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
    step();
    // Branch overrides the load-use stall.
    idex_rt = 5'd8; ifid_rs = 5'd8; branch_taken = 1'b1;
    base = stall_cycles;
    step();
    check_val("branch_no_stall_count", stall_cycles, base);
    idle_inputs();
    step();

    // MULT: busy for 4 cycles, one done pulse.
    obs_busy = 0; obs_done = 0;
    md_start = 1'b1; md_is_div = 1'b0;
    step();
    md_start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check_val("mul_busy_cycles", obs_busy, MUL_LAT);
    check_val("mul_done_pulses", obs_done, 32'd1);

    // DIV with MFHI in ID from the issue cycle: 33 stalled cycles.
    base = stall_cycles;
    md_start = 1'b1; md_is_div = 1'b1; ifid_reads_hilo = 1'b1;
    step();
    md_start = 1'b0;
    for (int i = 0; i < DIV_LAT; i++) step();
    check_val("div_mfhi_stalls", stall_cycles - base, 32'd33);
    check_val("mfhi_release_pc", {31'd0, pc_write}, 32'd1);
    step();
    idle_inputs();

    // Second MULT in ID while DIV busy, then a fresh MULT after release.
    md_start = 1'b1; md_is_div = 1'b1;
    step();
    md_start = 1'b0; ifid_is_md = 1'b1;
    for (int i = 0; i < DIV_LAT; i++) step();
    obs_busy = 0; obs_done = 0;
    md_start = 1'b1; md_is_div = 1'b0;
    step();
    md_start = 1'b0; ifid_is_md = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_val("remul_busy_cycles", obs_busy, MUL_LAT);
    check_val("remul_done_pulses", obs_done, 32'd1);

    // Reset in the middle of a DIV (count at 10).
    obs_done = 0;
    md_start = 1'b1; md_is_div = 1'b1;
    step();
    md_start = 1'b0;
    for (int i = 0; i < 21; i++) step();
    #1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_md_busy", {31'd0, md_busy}, 32'd0);
    check_val("midrst_md_done", {31'd0, md_done}, 32'd0);
    check_val("midrst_stalls",  stall_cycles,     32'd0);
    md_act = 1'b0; m_stalls = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check_val("midrst_no_done", obs_done, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      ifid_rs         = 5'($urandom_range(0, 3));
      ifid_rt         = 5'($urandom_range(0, 3));
      idex_rt         = 5'($urandom_range(0, 3));
      ifid_uses_rt    = 1'($urandom_range(0, 1));
      idex_memread    = 1'($urandom_range(0, 1));
      ifid_reads_hilo = ($urandom_range(0, 3) == 0);
      ifid_is_md      = ($urandom_range(0, 4) == 0);
      md_start        = ($urandom_range(0, 7) == 0);
      md_is_div       = ($urandom_range(0, 3) == 0);
      branch_taken    = ($urandom_range(0, 5) == 0);
      jump            = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
